// File: rtl/param_adder_pkg.sv
// Shared types and elaboration helpers for the serial adder/subtractor.
// Holds the FSM state encoding, counter sizing and the operand/slice width check.
package param_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-slice instance still needs a 1-bit counter.
  function automatic int cnt_width(input int nslice);
    return (nslice <= 1) ? 1 : $clog2(nslice);
  endfunction

  function automatic bit width_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/slice_adder.sv
// Combinational CHUNK-bit adder with carry in/out.
// One instance is time-shared across all slices of an operation.
module slice_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/param_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor, one CHUNK-bit slice per clock.
// Valid/ready on both sides; result held in DONE until the consumer takes it.
module param_serial_adder
  import param_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
    $fatal(1, "param_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
  logic             cout_q, out_valid_q;

  logic [WIDTH-1:0] a_sh_d, b_sh_d, sum_d;
  logic [CHUNK-1:0] slice_s;
  logic             slice_c;

  slice_adder #(.CHUNK(CHUNK)) u_slice (
    .a  (a_sh_q[CHUNK-1:0]),
    .b  (b_sh_q[CHUNK-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_c)
  );

  assign a_sh_d = a_sh_q >> CHUNK;
  assign b_sh_d = b_sh_q >> CHUNK;

  // New slice enters at the MSB end so the LSB slice lands at bit 0 after NSLICE shifts.
  if (NSLICE == 1) begin : g_one_slice
    assign sum_d = slice_s;
  end else begin : g_multi_slice
    assign sum_d = {slice_s, sum_q[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q  <= a;
            b_sh_q  <= sub ? ~b : b;
            carry_q <= sub ^ cin;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          carry_q <= slice_c;
          sum_q   <= sum_d;
          a_sh_q  <= a_sh_d;
          b_sh_q  <= b_sh_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cout_q      <= slice_c;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_param_serial_adder.sv
// Directed bench for param_serial_adder: a 16/4 instance and a degenerate 8/8 instance.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_param_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv16 = 1'b0, ir16, cin16 = 1'b0, sub16 = 1'b0, ov16, or16 = 1'b0, co16, busy16;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        iv8 = 1'b0, ir8, cin8 = 1'b0, sub8 = 1'b0, ov8, or8 = 1'b0, co8, busy8;
  logic [7:0]  a8 = '0, b8 = '0, s8;

  int n_checks = 0;
  int n_fail   = 0;

  param_serial_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
    .cout(co16), .busy(busy16)
  );

  param_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .cout(co8), .busy(busy8)
  );

  // Issues one operation, scrambles the inputs after the accept, and waits in DONE.
  task automatic run_op16(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tc, input logic ts,
                          output int lat, output bit tmo);
    @(negedge clk);
    a16 = ta; b16 = tb_v; cin16 = tc; sub16 = ts; iv16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0; a16 = 16'hDEAD; b16 = 16'hBEEF; cin16 = ~tc; sub16 = ~ts;
    lat = 0; tmo = 1'b0;
    while (!ov16) begin
      if (lat >= 40) begin tmo = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handoff16();
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", ir16); end
    n_checks++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", ov16); end
    n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy16); end
    n_checks++; if (s16 !== 16'h0000 || co16 !== 1'b0) begin n_fail++; $display("FAIL reset_sum got=%h/%b exp=0000/0", s16, co16); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat; bit tmo;
    run_op16(16'h1234, 16'h1111, 1'b0, 1'b0, lat, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL add_timeout got=timeout exp=out_valid"); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_latency got=%0d exp=4", lat); end
    n_checks++; if (s16 !== 16'h2345) begin n_fail++; $display("FAIL add_sum got=%h exp=2345", s16); end
    n_checks++; if (co16 !== 1'b0) begin n_fail++; $display("FAIL add_cout got=%b exp=0", co16); end
    handoff16();
    n_checks++; if (ir16 !== 1'b1 || ov16 !== 1'b0) begin n_fail++; $display("FAIL add_handoff got=ir%b/ov%b exp=ir1/ov0", ir16, ov16); end
  endtask

  task automatic test_ripple();
    int lat; bit tmo;
    run_op16(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat, tmo);
    n_checks++; if (tmo || lat !== 4) begin n_fail++; $display("FAIL ripple_latency got=%0d tmo=%b exp=4", lat, tmo); end
    n_checks++; if (s16 !== 16'h0000) begin n_fail++; $display("FAIL ripple_sum got=%h exp=0000", s16); end
    n_checks++; if (co16 !== 1'b1) begin n_fail++; $display("FAIL ripple_cout got=%b exp=1", co16); end
    handoff16();
  endtask

  task automatic test_sub();
    int lat; bit tmo;
    run_op16(16'h0005, 16'h0007, 1'b0, 1'b1, lat, tmo);
    n_checks++; if (tmo || lat !== 4) begin n_fail++; $display("FAIL sub1_latency got=%0d tmo=%b exp=4", lat, tmo); end
    n_checks++; if (s16 !== 16'hFFFE) begin n_fail++; $display("FAIL sub1_sum got=%h exp=fffe", s16); end
    n_checks++; if (co16 !== 1'b0) begin n_fail++; $display("FAIL sub1_cout got=%b exp=0", co16); end
    handoff16();
    run_op16(16'h0007, 16'h0005, 1'b1, 1'b1, lat, tmo);
    n_checks++; if (tmo || lat !== 4) begin n_fail++; $display("FAIL sub2_latency got=%0d tmo=%b exp=4", lat, tmo); end
    n_checks++; if (s16 !== 16'h0001) begin n_fail++; $display("FAIL sub2_sum got=%h exp=0001", s16); end
    n_checks++; if (co16 !== 1'b1) begin n_fail++; $display("FAIL sub2_cout got=%b exp=1", co16); end
    handoff16();
  endtask

  task automatic test_backpressure();
    int lat; bit tmo;
    run_op16(16'h0F0F, 16'h0101, 1'b0, 1'b0, lat, tmo);
    n_checks++; if (tmo || s16 !== 16'h1010) begin n_fail++; $display("FAIL bp_first_sum got=%h tmo=%b exp=1010", s16, tmo); end
    for (int i = 0; i < 3; i++) begin
      a16 = 16'hAAAA + 16'(i); b16 = 16'h5555; cin16 = 1'b1; sub16 = 1'b0; iv16 = 1'b1;
      @(negedge clk);
      n_checks++; if (ov16 !== 1'b1 || ir16 !== 1'b0 || busy16 !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold_flags got=ov%b/ir%b/busy%b exp=ov1/ir0/busy1", ov16, ir16, busy16); end
      n_checks++; if (s16 !== 16'h1010 || co16 !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold_sum got=%h/%b exp=1010/0", s16, co16); end
    end
    iv16 = 1'b0;
    handoff16();
    n_checks++; if (ir16 !== 1'b1 || ov16 !== 1'b0 || busy16 !== 1'b0) begin
      n_fail++; $display("FAIL bp_release got=ir%b/ov%b/busy%b exp=ir1/ov0/busy0", ir16, ov16, busy16); end
    n_checks++; if (s16 !== 16'h1010) begin n_fail++; $display("FAIL bp_sum_kept got=%h exp=1010", s16); end
    run_op16(16'h0001, 16'h0002, 1'b0, 1'b0, lat, tmo);
    n_checks++; if (tmo || lat !== 4) begin n_fail++; $display("FAIL bp_next_latency got=%0d tmo=%b exp=4", lat, tmo); end
    n_checks++; if (s16 !== 16'h0003 || co16 !== 1'b0) begin n_fail++; $display("FAIL bp_next_sum got=%h/%b exp=0003/0", s16, co16); end
    handoff16();
  endtask

  task automatic test_reset_mid_calc();
    int lat; bit tmo;
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    n_checks++; if (busy16 !== 1'b1 || ir16 !== 1'b0) begin n_fail++; $display("FAIL calc_busy got=busy%b/ir%b exp=busy1/ir0", busy16, ir16); end
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ir16 !== 1'b1 || busy16 !== 1'b0 || ov16 !== 1'b0) begin
      n_fail++; $display("FAIL midreset_flags got=ir%b/busy%b/ov%b exp=ir1/busy0/ov0", ir16, busy16, ov16); end
    n_checks++; if (s16 !== 16'h0000 || co16 !== 1'b0) begin n_fail++; $display("FAIL midreset_sum got=%h/%b exp=0000/0", s16, co16); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op16(16'h00FF, 16'h0001, 1'b0, 1'b0, lat, tmo);
    n_checks++; if (tmo || lat !== 4) begin n_fail++; $display("FAIL postreset_latency got=%0d tmo=%b exp=4", lat, tmo); end
    n_checks++; if (s16 !== 16'h0100 || co16 !== 1'b0) begin n_fail++; $display("FAIL postreset_sum got=%h/%b exp=0100/0", s16, co16); end
    handoff16();
  endtask

  task automatic test_degenerate();
    int lat;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
    lat = 0;
    while (!ov8 && lat < 40) begin @(negedge clk); lat++; end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL deg_latency got=%0d exp=1", lat); end
    n_checks++; if (s8 !== 8'h00 || co8 !== 1'b1) begin n_fail++; $display("FAIL deg_sum got=%h/%b exp=00/1", s8, co8); end
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    n_checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0) begin n_fail++; $display("FAIL deg_handoff got=ir%b/ov%b exp=ir1/ov0", ir8, ov8); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ripple();
    test_sub();
    test_backpressure();
    test_reset_mid_calc();
    test_degenerate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
